// File: rtl/cgra_config_sequencer.sv
// Byte-stream configuration sequencer for a small CGRA: decodes WRITE/RUN/CLEAR
// packets into config writes, commits, tile clears and timed runs. Optional macro: CFG_CHECKSUM_EN.
module cgra_config_sequencer #(
  parameter int NUM_TILES = 4,
  parameter int ADDR_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           i_in_data,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic                 o_cfg_we,
  output logic [1:0]           o_cfg_tile,
  output logic [ADDR_W-1:0]    o_cfg_addr,
  output logic [7:0]           o_cfg_data,
  output logic [NUM_TILES-1:0] o_cfg_commit,
  output logic [NUM_TILES-1:0] o_tile_clr,
  output logic                 o_run,
  output logic                 o_done,
  output logic                 o_err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_PAYLOAD,
`ifdef CFG_CHECKSUM_EN
    S_CHECK,
`endif
    S_COMMIT,
    S_RUNCNT,
    S_RUNNING
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  function automatic logic [NUM_TILES-1:0] tileHot(input logic [1:0] t);
    tileHot = {{(NUM_TILES-1){1'b0}}, 1'b1} << t;
  endfunction

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_tile;
  logic [3:0]             r_len;
  logic [3:0]             r_idx;
  logic [7:0]             r_runCnt;
  logic                   r_cfgWe;
  logic [1:0]             r_cfgTile;
  logic [ADDR_W-1:0]      r_cfgAddr;
  logic [7:0]             r_cfgData;
  logic [NUM_TILES-1:0]   r_clr;
  logic                   r_done;
  logic                   r_err;
`ifdef CFG_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  logic                   w_readyState;
  logic                   w_accept;
  logic [1:0]             w_op;

  assign w_op         = i_in_data[7:6];
  assign w_readyState = (r_state == S_HDR) || (r_state == S_PAYLOAD) ||
`ifdef CFG_CHECKSUM_EN
                        (r_state == S_CHECK) ||
`endif
                        (r_state == S_RUNCNT);
  // Ready is forced low while reset is held so nothing is accepted in that cycle.
  assign o_in_ready   = w_readyState && !reset;
  assign w_accept     = i_in_valid && o_in_ready;

  assign o_cfg_we     = r_cfgWe;
  assign o_cfg_tile   = r_cfgTile;
  assign o_cfg_addr   = r_cfgAddr;
  assign o_cfg_data   = r_cfgData;
  assign o_tile_clr   = r_clr;
  assign o_done       = r_done;
  assign o_err        = r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_cfg_commit = '0;
    o_run        = 1'b0;
    case (r_state)
      S_HDR: begin
        if (w_accept) begin
          if (w_op == OP_WRITE) begin
            w_next = S_PAYLOAD;
          end else if (w_op == OP_RUN) begin
            w_next = S_RUNCNT;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept && (r_idx == r_len)) begin
`ifdef CFG_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_COMMIT;
`endif
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          w_next = (i_in_data == r_csum) ? S_COMMIT : S_HDR;
        end
      end
`endif
      S_COMMIT: begin
        o_cfg_commit = reset ? '0 : tileHot(r_tile);
        w_next       = S_HDR;
      end
      S_RUNCNT: begin
        if (w_accept) begin
          w_next = (i_in_data == 8'd0) ? S_HDR : S_RUNNING;
        end
      end
      S_RUNNING: begin
        o_run = !reset;
        if (r_runCnt == 8'd1) begin
          w_next = S_HDR;
        end
      end
      default: w_next = S_HDR;
    endcase
  end

  // Datapath: header fields, payload index, run counter and the registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tile    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_runCnt  <= '0;
      r_cfgWe   <= 1'b0;
      r_cfgTile <= '0;
      r_cfgAddr <= '0;
      r_cfgData <= '0;
      r_clr     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_cfgWe <= 1'b0;
      r_clr   <= '0;
      r_done  <= 1'b0;
      case (r_state)
        S_HDR: begin
          if (w_accept) begin
            r_tile <= i_in_data[5:4];
            r_len  <= i_in_data[3:0];
            r_idx  <= '0;
`ifdef CFG_CHECKSUM_EN
            r_csum <= i_in_data;
`endif
            if (w_op == OP_CLEAR) begin
              r_clr <= tileHot(i_in_data[5:4]);
            end else if (w_op == 2'b11) begin
              r_err <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_cfgWe   <= 1'b1;
            r_cfgTile <= r_tile;
            r_cfgAddr <= ADDR_W'(r_idx);
            r_cfgData <= i_in_data;
            r_idx     <= r_idx + 4'd1;
`ifdef CFG_CHECKSUM_EN
            r_csum    <= r_csum ^ i_in_data;
`endif
          end
        end
`ifdef CFG_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept && (i_in_data != r_csum)) begin
            r_err <= 1'b1;
          end
        end
`endif
        S_RUNCNT: begin
          if (w_accept) begin
            r_runCnt <= i_in_data;
            if (i_in_data == 8'd0) begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUNNING: begin
          r_runCnt <= r_runCnt - 8'd1;
          if (r_runCnt == 8'd1) begin
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Scoreboard bench for cgra_config_sequencer: drivers push cycle-stamped expected events,
// a negedge monitor turns DUT outputs into events and compares them in order.
module tb_cgra_config_sequencer;

  localparam int NUM_TILES = 4;
  localparam int ADDR_W    = 3;

  localparam int K_WR     = 0;
  localparam int K_COMMIT = 1;
  localparam int K_CLR    = 2;
  localparam int K_RUN    = 3;
  localparam int K_DONE   = 4;
  localparam int K_ERR    = 5;
  localparam int K_ERRCLR = 6;

  typedef struct {
    int kind;
    int stamp;
    int a;
    int b;
    int c;
  } event_t;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [7:0]           inData = 8'h00;
  logic                 inValid = 1'b0;
  logic                 inReady;
  logic                 cfgWe;
  logic [1:0]           cfgTile;
  logic [ADDR_W-1:0]    cfgAddr;
  logic [7:0]           cfgData;
  logic [NUM_TILES-1:0] cfgCommit;
  logic [NUM_TILES-1:0] tileClr;
  logic                 run;
  logic                 done;
  logic                 err;

  int     cycle = 0;
  int     vectors = 0;
  int     miscompares = 0;
  event_t expQ[$];
  bit     errModel = 1'b0;

  cgra_config_sequencer #(.NUM_TILES(NUM_TILES), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .i_in_data(inData),
    .i_in_valid(inValid),
    .o_in_ready(inReady),
    .o_cfg_we(cfgWe),
    .o_cfg_tile(cfgTile),
    .o_cfg_addr(cfgAddr),
    .o_cfg_data(cfgData),
    .o_cfg_commit(cfgCommit),
    .o_tile_clr(tileClr),
    .o_run(run),
    .o_done(done),
    .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic event_t mkEv(input int kind, input int stamp, input int a, input int b, input int c);
    event_t e;
    e.kind = kind; e.stamp = stamp; e.a = a; e.b = b; e.c = c;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic scoreEvent(input event_t obs);
    event_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL unexpected event: got kind=%0d cycle=%0d a=%0d b=%0d c=%0d, expected none",
               obs.kind, obs.stamp, obs.a, obs.b, obs.c);
    end else begin
      e = expQ.pop_front();
      if (e.kind != obs.kind || e.stamp != obs.stamp || e.a != obs.a || e.b != obs.b || e.c != obs.c) begin
        miscompares++;
        $display("[TB] FAIL event kind=%0d: got kind=%0d cycle=%0d a=%0d b=%0d c=%0d, expected kind=%0d cycle=%0d a=%0d b=%0d c=%0d",
                 e.kind, obs.kind, obs.stamp, obs.a, obs.b, obs.c, e.kind, e.stamp, e.a, e.b, e.c);
      end
    end
  endtask

  // Drive one byte and wait for it to be accepted; stamp is the cycle its effects appear.
  task automatic applyStimulus(input logic [7:0] b, output int stamp);
    int waited = 0;
    stamp = -1;
    @(posedge clk); #1;
    inValid = 1'b1;
    inData  = b;
    while (1) begin
      @(negedge clk);
      if (inReady) begin
        stamp = cycle + 1;
        break;
      end
      waited++;
      if (waited > 1000) begin
        miscompares++;
        $display("[TB] FAIL accept timeout: byte %02h not accepted, expected acceptance within 1000 cycles", b);
        break;
      end
    end
  endtask

  task automatic releaseBus(input int n);
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic noteErr(input int stamp);
    if (!errModel) expQ.push_back(mkEv(K_ERR, stamp, 0, 0, 0));
    errModel = 1'b1;
  endtask

  // forceSum < 0 sends the correct checksum in checksum builds.
  task automatic writePacket(input logic [1:0] tile, input logic [7:0] pay[$],
                             input int stallAt, input int stallLen, input int forceSum);
    logic [7:0] hdr;
    logic [7:0] sum;
    int st;
    hdr = {2'b00, tile, 4'(pay.size() - 1)};
    applyStimulus(hdr, st);
    sum = hdr;
    for (int k = 0; k < pay.size(); k++) begin
      if (k == stallAt) releaseBus(stallLen);
      applyStimulus(pay[k], st);
      sum ^= pay[k];
      expQ.push_back(mkEv(K_WR, st, tile, k % (1 << ADDR_W), pay[k]));
    end
`ifdef CFG_CHECKSUM_EN
    if (forceSum >= 0 && forceSum[7:0] != sum) begin
      applyStimulus(forceSum[7:0], st);
      noteErr(st);
    end else begin
      applyStimulus(sum, st);
      expQ.push_back(mkEv(K_COMMIT, st, 0, 1 << tile, 0));
    end
`else
    if (forceSum < -1) $display("[TB] note: checksum override ignored");
    expQ.push_back(mkEv(K_COMMIT, st, 0, 1 << tile, 0));
`endif
    releaseBus(1);
  endtask

  task automatic runCmd(input logic [1:0] tile, input logic [7:0] n);
    int st;
    applyStimulus({2'b01, tile, 4'(($urandom) & 15)}, st);
    applyStimulus(n, st);
    if (n == 0) begin
      expQ.push_back(mkEv(K_DONE, st, 0, 0, 0));
    end else begin
      expQ.push_back(mkEv(K_RUN, st, 0, n, 0));
      expQ.push_back(mkEv(K_DONE, st + n, 0, 0, 0));
    end
    releaseBus(1);
  endtask

  task automatic clearCmd(input logic [1:0] tile);
    int st;
    applyStimulus({2'b10, tile, 4'(($urandom) & 15)}, st);
    expQ.push_back(mkEv(K_CLR, st, 0, 1 << tile, 0));
    releaseBus(1);
  endtask

  task automatic illegalCmd(input logic [5:0] low);
    int st;
    applyStimulus({2'b11, low}, st);
    noteErr(st);
    releaseBus(1);
  endtask

  task automatic randomPayload(input int len, output logic [7:0] pay[$]);
    pay = {};
    for (int k = 0; k <= len; k++) pay.push_back(8'($urandom));
  endtask

  // Monitor: converts each cycle's outputs into events in a fixed order.
  initial begin : monitor
    bit inRun = 1'b0;
    bit prevErr = 1'b0;
    int runStart = 0;
    int runLen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inRun = 1'b0;
        prevErr = 1'b0;
      end else begin
        if (cfgWe) scoreEvent(mkEv(K_WR, cycle, cfgTile, cfgAddr, cfgData));
        if (cfgCommit != 0) scoreEvent(mkEv(K_COMMIT, cycle, 0, cfgCommit, 0));
        if (tileClr != 0) scoreEvent(mkEv(K_CLR, cycle, 0, tileClr, 0));
        if (run) begin
          if (!inRun) begin
            runStart = cycle;
            runLen = 0;
          end
          inRun = 1'b1;
          runLen++;
          checkOutput("in_ready low while running", inReady, 0);
        end else if (inRun) begin
          inRun = 1'b0;
          scoreEvent(mkEv(K_RUN, runStart, 0, runLen, 0));
        end
        if (done) scoreEvent(mkEv(K_DONE, cycle, 0, 0, 0));
        if (err && !prevErr) scoreEvent(mkEv(K_ERR, cycle, 0, 0, 0));
        if (!err && prevErr) scoreEvent(mkEv(K_ERRCLR, cycle, 0, 0, 0));
        prevErr = err;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] pay[$];
    int st;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", inReady, 0);
    checkOutput("reset strobes", {cfgWe, cfgCommit, tileClr, done, run}, 0);
    checkOutput("reset err", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("in_ready after reset", inReady, 1);

    $display("[TB] directed WRITE tile 1");
    pay = '{8'hAA, 8'hBB, 8'hCC};
    writePacket(2'd1, pay, -1, 0, -1);

    $display("[TB] directed RUN 5 and RUN 0");
    runCmd(2'd0, 8'd5);
    runCmd(2'd0, 8'd0);

    $display("[TB] directed CLEAR tile 2");
    clearCmd(2'd2);

`ifdef CFG_CHECKSUM_EN
    $display("[TB] directed checksum match and mismatch");
    pay = '{8'h11};
    writePacket(2'd3, pay, -1, 0, 8'h21);
    writePacket(2'd3, pay, -1, 0, 8'h22);
    clearCmd(2'd0);
`endif

    $display("[TB] directed stall mid-payload with address wrap");
    randomPayload(11, pay);
    writePacket(2'd2, pay, 4, 10, -1);

    $display("[TB] directed illegal opcode");
    illegalCmd(6'h00);
    repeat (3) @(posedge clk);
    #1 checkOutput("err sticky", err, 1);

    $display("[TB] randomized commands");
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          randomPayload($urandom_range(0, 15), pay);
          writePacket(2'($urandom), pay, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1,
                      $urandom_range(1, 4), ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : -1);
        end
        4, 5, 6: runCmd(2'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 20)));
        7, 8: clearCmd(2'($urandom));
        default: illegalCmd(6'($urandom));
      endcase
    end

    $display("[TB] reset mid-packet");
    repeat (5) @(posedge clk);
    applyStimulus(8'h27, st);
    applyStimulus(8'h5A, st);
    expQ.push_back(mkEv(K_WR, st, 2, 0, 8'h5A));
    applyStimulus(8'h5B, st);
    expQ.push_back(mkEv(K_WR, st, 2, 1, 8'h5B));
    releaseBus(3);
    #1;
    reset = 1'b1;
    errModel = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 checkOutput("in_ready after mid-packet reset", inReady, 1);
    clearCmd(2'd3);

    $display("[TB] reset during RUN 200");
    runCmd(2'd1, 8'd200);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.delete();
    errModel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("run low after reset", run, 0);
    checkOutput("in_ready low during reset", inReady, 0);
    checkOutput("err cleared by reset", err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1 checkOutput("in_ready after run reset", inReady, 1);
    repeat (20) @(posedge clk);
    pay = '{8'h01, 8'h02};
    writePacket(2'd0, pay, -1, 0, -1);

    repeat (40) @(posedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cgra_config_sequencer.md
CGRA_CONFIG_SEQUENCER -- requirements
Module: cgra_config_sequencer

Interface
REQ-001 Parameter NUM_TILES, default 4: number of compute tiles addressed; tile field is 2 bits wide.
REQ-002 Parameter ADDR_W, default 4: per-tile config register address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  8  command/payload byte stream.
REQ-006 in_valid  input  1  in_data valid; byte accepted on a cycle with in_valid && in_ready.
REQ-007 in_ready  output  1  sequencer can accept a byte this cycle.
REQ-008 cfg_we  output  1  one-cycle config register write strobe.
REQ-009 cfg_tile  output  2  target tile index of the write.
REQ-010 cfg_addr  output  ADDR_W  target register address of the write.
REQ-011 cfg_data  output  8  write data.
REQ-012 cfg_commit  output  NUM_TILES  one-cycle one-hot pulse: tile applies its shadow config.
REQ-013 tile_clr  output  NUM_TILES  one-cycle one-hot pulse clearing a tile's PE state.
REQ-014 run  output  1  array enable, high while a RUN command executes.
REQ-015 done  output  1  one-cycle pulse when a RUN command completes.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 The header byte SHALL be decoded as op=[7:6], tile=[5:4], len=[3:0].
REQ-018 The FSM states SHALL be HDR, PAYLOAD, CHECK, COMMIT, RUNCNT, RUNNING; the FSM SHALL leave HDR only on an accepted header.
REQ-019 op=00 WRITE SHALL go to PAYLOAD and accept exactly len+1 bytes; payload byte k SHALL write address k.
REQ-020 Each accepted payload byte SHALL produce cfg_we=1 with tile/addr/data in the following cycle (latency 1); cfg_we SHALL be 0 otherwise.
REQ-021 After the last payload byte, the FSM SHALL go to CHECK if CFG_CHECKSUM_EN is defined, else to COMMIT.
REQ-022 COMMIT SHALL last one cycle, pulse cfg_commit[tile], and hold in_ready=0; the next state SHALL be HDR.
REQ-023 len values with len+1 > 2^ADDR_W SHALL wrap addresses modulo 2^ADDR_W; this SHALL NOT be an error.
REQ-024 op=01 RUN SHALL go to RUNCNT and accept one count byte N.
REQ-025 N=0 SHALL pulse done in the next cycle without asserting run, then return to HDR.
REQ-026 N>0 SHALL assert run for exactly N cycles starting the cycle after the count byte is accepted, hold in_ready=0, and pulse done in the cycle after run falls.
REQ-027 op=10 CLEAR SHALL pulse tile_clr[tile] in the next cycle, consume no payload, and remain in HDR.
REQ-028 op=11 is illegal: the byte SHALL be dropped, err SHALL be set, and the FSM SHALL stay in HDR.
REQ-029 in_ready SHALL be 1 in HDR, PAYLOAD, CHECK and RUNCNT, and 0 in COMMIT and RUNNING.
REQ-030 in_valid=0 mid-packet SHALL stall the FSM in its current state indefinitely with no timeout.
REQ-031 err SHALL clear only on reset.

Reset
REQ-032 Reset SHALL force state=HDR, all counters to 0, err=0, in_ready=0 during reset, and all strobes (cfg_we, cfg_commit, tile_clr, done) plus run to 0.
REQ-033 Reset mid-packet or mid-RUN SHALL abort the command: no commit, no done pulse, run=0 in the next cycle.
REQ-034 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-035 Macro CFG_CHECKSUM_EN defined: WRITE packets SHALL carry one trailing byte accepted in CHECK.
REQ-036 Macro CFG_CHECKSUM_EN defined: the trailing byte SHALL equal the XOR of the header and all payload bytes; on a match go to COMMIT; on a mismatch set err, issue no cfg_commit, and return to HDR.
REQ-037 Macro CFG_CHECKSUM_EN undefined: the CHECK state and checksum logic SHALL be absent, and COMMIT SHALL follow the last payload byte directly.

Verification
REQ-038 WRITE: bytes 0x12,0xAA,0xBB,0xCC (len=2, tile 1) -> cfg_we on 3 consecutive cycles, addr 0,1,2, data AA,BB,CC, then cfg_commit=0010.
REQ-039 RUN: bytes 0x40,0x05 -> run high for 5 cycles, in_ready low throughout, done pulse one cycle after; count byte 0x00 -> done only.
REQ-040 CFG_CHECKSUM_EN: 0x30,0x11,0x21 -> commit 1000; checksum byte 0x22 instead -> err=1, no commit, next header accepted.
REQ-041 Illegal/CLEAR: 0xC0 -> err=1, no strobes; 0xA0 -> tile_clr=0100 for one cycle.
REQ-042 Stall/reset: drop in_valid for 10 cycles mid-payload -> writes resume with correct addresses; assert reset during RUN N=200 -> run=0 next cycle, no done, in_ready=1 after release.
